// File: rtl/lfsr_seq_ctrl_if.sv
// Host-side start/busy/done bundle for lfsr_seq_ctrl.
interface lfsr_seq_ctrl_if #(
  parameter int RUN_W = 8
);
  logic             start;
  logic [5:0]       seed_word;
  logic [RUN_W-1:0] run_len;
  logic             busy;
  logic             done;
  logic [5:0]       result;
  logic             zero_seed;

  modport master (
    output start,
    output seed_word,
    output run_len,
    input  busy,
    input  done,
    input  result,
    input  zero_seed
  );

  modport slave (
    input  start,
    input  seed_word,
    input  run_len,
    output busy,
    output done,
    output result,
    output zero_seed
  );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Seeds a 6-bit Fibonacci LFSR serially, free-runs it, captures the state.
// Optional zero-seed substitution: define LFSR_CTRL_ZERO_GUARD_EN.
module lfsr_seq_ctrl #(
  parameter int RUN_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  lfsr_seq_ctrl_if.slave  host,
  input  logic [5:0]      lfsr_out,
  output logic            lfsr_enable,
  output logic            lfsr_seed
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_CAP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [5:0]       seed_q, seed_d;
  logic [2:0]       bit_q, bit_d;
  logic [RUN_W-1:0] step_q, step_d;
  logic             en_q, en_d;
  logic             sd_q, sd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [5:0]       res_q, res_d;
  logic [5:0]       seed_eff;

`ifdef LFSR_CTRL_ZERO_GUARD_EN
  logic zhit_q, zhit_d;
  logic zs_q, zs_d;

  // All-zero locks the LFSR up, so swap in the smallest live seed.
  assign seed_eff = (host.seed_word == 6'd0) ? 6'd1 : host.seed_word;
`else
  assign seed_eff = host.seed_word;
`endif

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    bit_d   = bit_q;
    step_d  = step_q;
    en_d    = en_q;
    sd_d    = sd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
`ifdef LFSR_CTRL_ZERO_GUARD_EN
    zhit_d  = zhit_q;
    zs_d    = zs_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (host.start) begin
          seed_d  = seed_eff;
          step_d  = host.run_len;
          bit_d   = 3'd5;
          en_d    = 1'b1;
          sd_d    = seed_eff[5];
          busy_d  = 1'b1;
          state_d = S_LOAD;
`ifdef LFSR_CTRL_ZERO_GUARD_EN
          zhit_d  = (host.seed_word == 6'd0);
          zs_d    = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (bit_q == 3'd0) begin
          en_d    = 1'b0;
          sd_d    = 1'b0;
          state_d = (step_q == '0) ? S_CAP : S_RUN;
        end else begin
          bit_d = bit_q - 3'd1;
          sd_d  = seed_q[bit_q - 3'd1];
        end
      end
      S_RUN: begin
        // Exit test precedes the decrement, so the counter never wraps.
        step_d = step_q - 1'b1;
        if (step_q == RUN_W'(1)) state_d = S_CAP;
      end
      S_CAP: begin
        res_d   = lfsr_out;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef LFSR_CTRL_ZERO_GUARD_EN
        zs_d    = zhit_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      seed_q  <= '0;
      bit_q   <= '0;
      step_q  <= '0;
      en_q    <= 1'b0;
      sd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      bit_q   <= bit_d;
      step_q  <= step_d;
      en_q    <= en_d;
      sd_q    <= sd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

`ifdef LFSR_CTRL_ZERO_GUARD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zhit_q <= 1'b0;
      zs_q   <= 1'b0;
    end else begin
      zhit_q <= zhit_d;
      zs_q   <= zs_d;
    end
  end

  assign host.zero_seed = zs_q;
`else
  assign host.zero_seed = 1'b0;
`endif

  assign lfsr_enable = en_q;
  assign lfsr_seed   = sd_q;
  assign host.busy   = busy_q;
  assign host.done   = done_q;
  assign host.result = res_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench for lfsr_seq_ctrl with a behavioural LFSR attached.
module tb_lfsr_seq_ctrl;

  localparam int RUN_W = 8;

  typedef struct {
    logic [5:0] res;
    logic       zs;
    int         done_cyc;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] lfsr_q = 6'h15;
  logic       lfsr_enable;
  logic       lfsr_seed;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         busy_cnt = 0;
  exp_t       sb[$];

  lfsr_seq_ctrl_if #(.RUN_W(RUN_W)) hif ();

  lfsr_seq_ctrl #(.RUN_W(RUN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (hif.slave),
    .lfsr_out    (lfsr_q),
    .lfsr_enable (lfsr_enable),
    .lfsr_seed   (lfsr_seed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    lfsr_q <= {lfsr_q[4:0], lfsr_enable ? lfsr_seed : (lfsr_q[5] ^ lfsr_q[4])};
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [5:0] lfsr_adv(logic [5:0] s, int n);
    logic [5:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = {v[4:0], v[5] ^ v[4]};
    return v;
  endfunction

  function automatic exp_t model(logic [5:0] seed, int rl, int acc_cyc);
    exp_t e;
    logic [5:0] s;
    s = seed;
    e.zs = 1'b0;
`ifdef LFSR_CTRL_ZERO_GUARD_EN
    if (seed == 6'd0) begin
      s = 6'd1;
      e.zs = 1'b1;
    end
`endif
    e.res      = lfsr_adv(s, rl);
    e.lat      = rl + 7;
    e.done_cyc = acc_cyc + rl + 7;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (hif.busy) busy_cnt++;
      if (hif.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("result", int'(hif.result), int'(e.res));
          chk("zero_seed", int'(hif.zero_seed), int'(e.zs));
          chk("done_cycle", cyc, e.done_cyc);
          chk("busy_len", busy_cnt, e.lat);
          chk("busy_at_done", int'(hif.busy), 0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic chk_idle_outs(string tag);
    chk({tag, "_en"}, int'(lfsr_enable), 0);
    chk({tag, "_seed"}, int'(lfsr_seed), 0);
    chk({tag, "_busy"}, int'(hif.busy), 0);
    chk({tag, "_done"}, int'(hif.done), 0);
    chk({tag, "_result"}, int'(hif.result), 0);
    chk({tag, "_zero"}, int'(hif.zero_seed), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((hif.busy || hif.done) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  // Returns at the negedge after the accepting edge, start released.
  task automatic issue(logic [5:0] seed, int rl);
    wait_idle();
    hif.start     = 1'b1;
    hif.seed_word = seed;
    hif.run_len   = RUN_W'(rl);
    sb.push_back(model(seed, rl, cyc + 1));
    @(negedge clk);
    hif.start     = 1'b0;
    hif.seed_word = 6'($urandom);
    hif.run_len   = RUN_W'($urandom);
  endtask

  task automatic reset_after(int n, logic [5:0] seed, int rl, string tag);
    issue(seed, rl);
    repeat (n) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle_outs(tag);
    sb.delete();
    repeat (2) @(negedge clk);
    chk_idle_outs({tag, "_held"});
    rst_n = 1'b1;
    issue(6'b000001, 5);
  endtask

  initial begin
    logic [5:0] sv;
    int c0;
    int n;
    hif.start     = 1'b0;
    hif.seed_word = '0;
    hif.run_len   = '0;
    #12;
    chk_idle_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Serial seed order and basic latency.
    sv = 6'b000001;
    issue(sv, 0);
    for (int i = 0; i < 6; i++) begin
      chk("load_en", int'(lfsr_enable), 1);
      chk("load_bit", int'(lfsr_seed), int'(sv[5 - i]));
      @(negedge clk);
    end
    chk("run_en", int'(lfsr_enable), 0);

    issue(6'b000001, 5);
    issue(6'b000001, 6);
    issue(6'b000001, 63);
    issue(6'b000000, 3);
    issue(6'($urandom), 255);

    reset_after(3, 6'b110011, 10, "rst_load");
    reset_after(10, 6'b011110, 20, "rst_run");

    // Start held high: second request lands one cycle after done.
    wait_idle();
    c0 = cyc;
    hif.start     = 1'b1;
    hif.seed_word = 6'b101010;
    hif.run_len   = RUN_W'(1);
    sb.push_back(model(6'b101010, 1, c0 + 1));
    sb.push_back(model(6'b101010, 1, c0 + 10));
    while (cyc < c0 + 10) @(negedge clk);
    hif.start = 1'b0;

    for (int k = 0; k < 16; k++) begin
      issue(6'($urandom_range(0, 63)), int'($urandom_range(0, 24)));
    end

    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
